// File: rtl/conv_frame_encoder.sv
`default_nettype none
// ============================================================================
// conv_frame_encoder : framed rate-1/2 K=3 (7,5) convolutional encoder with
//                      zero-tail termination and a valid/ready output slot
// Revision 1.0
// ============================================================================
module conv_frame_encoder (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] enc_state
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_DATA  = 2'd1;
  localparam logic [1:0] c_TAIL  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] r_sreg;
  logic [7:0] r_bit_cnt;
  logic [1:0] r_tail_cnt;
  logic       r_out_valid;
  logic [1:0] r_out_sym;
  logic       r_out_last;
  logic       r_frame_done;

  logic       w_slot_free;
  logic       w_in_hs;
  logic       w_tail_load;
  logic       w_frame_start;
  logic       w_load;
  logic       w_u;
  logic       w_final_out_hs;

  assign w_slot_free    = !r_out_valid || out_ready;
  assign w_in_hs        = in_valid && in_ready;
  assign w_load         = w_in_hs || w_tail_load;
  assign w_u            = (r_state == c_TAIL) ? 1'b0 : in_bit;
  assign w_final_out_hs = r_out_valid && out_ready && r_out_last;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (start && frame_len != 8'd0) w_next_state = c_DATA;
      c_DATA:  if (w_in_hs && r_bit_cnt == 8'd1) w_next_state = c_TAIL;
      c_TAIL:  if (w_slot_free && r_tail_cnt == 2'd1) w_next_state = c_DRAIN;
      c_DRAIN: if (w_final_out_hs) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // in_ready is forced low while rst is high, whatever the current state
  always_comb begin
    in_ready      = 1'b0;
    busy          = 1'b0;
    w_tail_load   = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      c_IDLE: w_frame_start = start && (frame_len != 8'd0);
      c_DATA: begin
        busy     = 1'b1;
        in_ready = w_slot_free && !rst;
      end
      c_TAIL: begin
        busy        = 1'b1;
        w_tail_load = w_slot_free;
      end
      c_DRAIN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_sreg       <= 2'b00;
      r_bit_cnt    <= 8'd0;
      r_tail_cnt   <= 2'd0;
      r_out_valid  <= 1'b0;
      r_out_sym    <= 2'b00;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == c_DRAIN) && w_final_out_hs;
      if (w_frame_start) begin
        r_bit_cnt <= frame_len;
        r_sreg    <= 2'b00;
      end
      if (w_in_hs) begin
        r_bit_cnt <= r_bit_cnt - 8'd1;
        if (r_bit_cnt == 8'd1) r_tail_cnt <= 2'd2;
      end
      if (w_tail_load) r_tail_cnt <= r_tail_cnt - 2'd1;
      if (w_load) begin
        r_out_sym   <= {w_u ^ r_sreg[1] ^ r_sreg[0], w_u ^ r_sreg[0]};
        r_out_valid <= 1'b1;
        r_out_last  <= w_tail_load && (r_tail_cnt == 2'd1);
        r_sreg      <= {w_u, r_sreg[1]};
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sym    = r_out_sym;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign enc_state  = r_sreg;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_encoder.sv
`default_nettype none
// ============================================================================
// tb_conv_frame_encoder : directed self-checking bench for conv_frame_encoder
// Revision 1.0
// ============================================================================
module tb_conv_frame_encoder;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_sym;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic [1:0] enc_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  conv_frame_encoder dut (
    .clock(clock), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_sym(out_sym), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .enc_state(enc_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Symbols are sampled at the falling edge, ahead of the handshake edge
  always @(negedge clock) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_last, out_sym});
      if (out_last) last_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference (7,5) encoder with two zero tail bits
  task automatic build_exp(input int len, input logic [255:0] bits);
    logic [1:0] s;
    logic       u;
    s = 2'b00;
    exp_q.delete();
    for (int i = 0; i < len + 2; i++) begin
      u = (i < len) ? bits[i] : 1'b0;
      exp_q.push_back({(i == len + 1), u ^ s[1] ^ s[0], u ^ s[0]});
      s = {u, s[1]};
    end
  endtask

  task automatic drive_frame(input int len, input logic [255:0] bits, input bit gaps);
    int n;
    @(posedge clock); #1;
    start = 1'b1;
    frame_len = len[7:0];
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_bit = bits[i];
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 2000) begin
        n++;
        @(negedge clock);
      end
      if (n >= 2000) begin
        check("in_ready_timeout", 0, 1);
        i = len;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) check("done_timeout", 0, 1);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_sym"}, {29'd0, got_q[i]}, {29'd0, exp_q[i]});
    got_q.delete();
  endtask

  bit rnd_ready = 1'b0;
  always @(posedge clock) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int d0;
    logic [255:0] rb;
    int rl;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_enc_state", enc_state, 0);
    @(posedge clock); #1;
    rst = 1'b0;

    // Basic frame 1,0,1,1 -> 11 10 00 01 01 11
    exp_q.delete();
    exp_q.push_back(3'b011); exp_q.push_back(3'b010); exp_q.push_back(3'b000);
    exp_q.push_back(3'b001); exp_q.push_back(3'b001); exp_q.push_back(3'b111);
    d0 = done_cnt;
    drive_frame(4, 256'b1101, 1'b0);
    wait_done(d0);
    compare_q("basic");
    check("basic_done_lat", done_cyc - last_cyc, 1);
    check("basic_done_cnt", done_cnt - d0, 1);
    check("basic_busy_at_done", busy, 0);
    @(negedge clock);
    check("basic_done_pulse", frame_done, 0);
    check("basic_enc_state", enc_state, 0);

    // Backpressure after the first symbol
    build_exp(4, 256'b1101);
    out_ready = 1'b0;
    d0 = done_cnt;
    fork
      drive_frame(4, 256'b1101, 1'b0);
      begin
        int n;
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge clock);
        end
        repeat (3) begin
          @(negedge clock);
          check("bp_valid", out_valid, 1);
          check("bp_sym", out_sym, 2'b11);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    wait_done(d0);
    compare_q("bp");

    // Single-bit frame: 11 10 11
    exp_q.delete();
    exp_q.push_back(3'b011); exp_q.push_back(3'b010); exp_q.push_back(3'b111);
    d0 = done_cnt;
    drive_frame(1, 256'b1, 1'b0);
    wait_done(d0);
    compare_q("len1");
    check("len1_busy_at_done", busy, 0);

    // Zero-length start is ignored
    @(posedge clock); #1;
    start = 1'b1;
    frame_len = 8'd0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("len0_busy", busy, 0);
    check("len0_count", got_q.size(), 0);

    // Start pulsed mid-frame is ignored
    build_exp(3, 256'b011);
    d0 = done_cnt;
    fork
      drive_frame(3, 256'b011, 1'b0);
      begin
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        frame_len = 8'd9;
        @(posedge clock); #1;
        start = 1'b0;
      end
    join
    wait_done(d0);
    compare_q("midstart");
    check("midstart_done_cnt", done_cnt - d0, 1);

    // Reset after the second data symbol
    @(posedge clock); #1;
    start = 1'b1;
    frame_len = 8'd4;
    @(posedge clock); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(posedge clock); #1;
    in_bit = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    check("rstmid_in_ready", in_ready, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("rstmid_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_enc_state", enc_state, 0);
    repeat (4) @(negedge clock);
    check("rstmid_no_tail", out_valid, 0);
    got_q.delete();
    build_exp(2, 256'b11);
    d0 = done_cnt;
    drive_frame(2, 256'b11, 1'b0);
    wait_done(d0);
    compare_q("after_rst");

    // Random frames, random valid and ready
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rl = (f == 2) ? 255 : $urandom_range(1, 40);
      for (int i = 0; i < 256; i += 32) rb[i +: 32] = $urandom;
      build_exp(rl, rb);
      d0 = done_cnt;
      drive_frame(rl, rb, 1'b1);
      wait_done(d0);
      compare_q("rand");
      check("rand_enc_state", enc_state, 0);
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
